regfile_write_buffer: RTL
=========================

# regfile_write_buffer

Small in-order write queue that sits directly upstream of the 32x32 `regfile`. It accepts register write requests over a valid/ready handshake and drains them into the regfile's single write port one per cycle. Draining pauses while `Hold` is asserted. The two read ports are forwarded from pending entries, so reads always see the newest value, committed or not.

## Interface

Parameters:
- `DEPTH`, 4: number of queue entries, power of two, 2..16.
- `ADDR_WIDTH`, 5: register address width.
- `DATA_WIDTH`, 32: register data width.

Ports:
- `Clk` in 1: clock. One clock; all state updates on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `InValid` in 1: write request valid.
- `InReady` out 1: queue can accept a request.
- `InRegister` in `ADDR_WIDTH`: destination register of the request.
- `InData` in `DATA_WIDTH`: write data of the request.
- `Hold` in 1: stall drain; write port is in use by another agent.
- `WriteRegister` out `ADDR_WIDTH`: to regfile.
- `WriteData` out `DATA_WIDTH`: to regfile.
- `RegWrite` out 1: to regfile write enable.
- `ReadRegister1` in `ADDR_WIDTH`: read address 1; also wired directly to the regfile.
- `ReadRegister2` in `ADDR_WIDTH`: read address 2; also wired directly to the regfile.
- `RegReadData1` in `DATA_WIDTH`: regfile `ReadData1`.
- `RegReadData2` in `DATA_WIDTH`: regfile `ReadData2`.
- `ReadData1` out `DATA_WIDTH`: forwarded read result, port 1.
- `ReadData2` out `DATA_WIDTH`: forwarded read result, port 2.
- `Count` out `$clog2(DEPTH+1)`: number of occupied entries.
- `Empty` out 1: `Count == 0`.

## Operation

- Storage is a circular buffer with head pointer, tail pointer and count. Entry = {register, data}.
- Accept: `InValid && InReady` at a rising edge.
  - `InRegister != 0`: entry is written at tail; tail increments mod `DEPTH`.
  - `InRegister == 0`: request is consumed but not enqueued, because register 0 is hardwired zero. Count is unchanged.
- `InReady = (Count != DEPTH)`. It is a function of registered state only and has no path from `Hold` or `InValid`. When full, a same-cycle pop does not open a slot for a push.
- Drain: `RegWrite = !Empty && !Hold && !Reset`.
  - `WriteRegister` and `WriteData` = head entry when `!Empty`, else 0.
  - At each edge with `RegWrite = 1`, the regfile captures the head entry, and head increments mod `DEPTH` on the same edge.
- Count update:
  - +1 on enqueue only.
  - −1 on pop only.
  - Unchanged on simultaneous enqueue and pop, or when neither occurs.
- Entries commit to the regfile strictly in acceptance order.
- Forwarding (combinational), per read port N:
  - If `ReadRegisterN == 0`: `ReadDataN = RegReadDataN`.
  - Else, if any occupied entry matches `ReadRegisterN`: `ReadDataN` = data of the newest such entry, i.e. the match closest to tail.
  - Else: `ReadDataN = RegReadDataN`.
  - The head entry being popped this cycle still forwards until the edge.
- Reset (edge with `Reset = 1`):
  - Head, tail and count go to 0 and all pending entries are discarded.
  - `RegWrite` is forced to 0 during any cycle with `Reset` high, so no partial commit occurs.
  - A request presented during reset is not accepted.

## Timing

- Reset values: `Count = 0`, `Empty = 1`, `InReady = 1`, `RegWrite = 0`, `WriteRegister = 0`, `WriteData = 0`. `ReadDataN` equals `RegReadDataN`.
- Accept at edge E:
  - Forwarded value is visible on `ReadDataN` immediately after E.
  - If the queue was empty and `Hold = 0`, `RegWrite = 1` in the cycle following E, and the regfile is updated at edge E+1.
- Throughput is one commit per cycle while `Hold = 0`. A sustained one request per cycle keeps `Count` constant.
- With `Hold = 1` and continuous requests, `InReady` drops after `DEPTH` accepts. It rises again in the cycle after the first pop.
- Wrap-around: pointers wrap modulo `DEPTH`. Forwarding priority follows age, not index.

## Test plan

1. **Single write.** Reset, then `Hold = 0` and push reg 5 = 0xDEADBEEF.
   - Cycle after accept: `RegWrite = 1`, `WriteRegister = 5`, `ReadData1` (addr 5) = 0xDEADBEEF.
   - After the next edge: `Empty = 1` and the regfile reads back 0xDEADBEEF.
2. **Fill under hold.** `Hold = 1`, push regs 1..4 with data 10, 20, 30, 40.
   - `Count = 4`, `InReady = 0`, and a 5th request is not accepted.
   - Release `Hold`: four consecutive `RegWrite` cycles with `WriteRegister` = 1, 2, 3, 4 and data 10..40, then `Empty = 1`.
3. **Newest-wins forwarding.** `Hold = 1`, push reg 7 = 11, then reg 7 = 22.
   - `ReadData1` and `ReadData2` (addr 7) = 22.
   - Release `Hold`: regfile reg 7 ends at 22, and forwarded reads stay 22 throughout the drain.
4. **Register 0 write.** Push reg 0 = 99.
   - Accepted (`InReady = 1`), `Count` stays 0, `RegWrite` never asserts.
   - Read of addr 0 returns 0.
5. **Simultaneous push/pop and wrap.** With `Count = 2`, push one request per cycle for 8 cycles.
   - `Count` stays 2, pointers wrap past `DEPTH`, commit order matches push order, and no entry is lost or duplicated.
6. **Reset mid-operation.** `Hold = 1`, `Count = 3`, then assert `Reset` for one cycle with `Hold = 0`.
   - `RegWrite = 0` during the reset cycle.
   - Afterwards `Count = 0` and `ReadDataN` equals the regfile outputs; the regfile holds no queued values.

Source files
------------

// File: rtl/regfile_write_buffer.sv
// In-order write queue ahead of the regfile write port, with newest-wins read forwarding.
// Commit one cycle after accept when idle; InReady depends only on registered count, Hold stalls drain.
module regfile_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         InValid,
    output logic                         InReady,
    input  logic [ADDR_WIDTH-1:0]        InRegister,
    input  logic [DATA_WIDTH-1:0]        InData,
    input  logic                         Hold,
    output logic [ADDR_WIDTH-1:0]        WriteRegister,
    output logic [DATA_WIDTH-1:0]        WriteData,
    output logic                         RegWrite,
    input  logic [ADDR_WIDTH-1:0]        ReadRegister1,
    input  logic [ADDR_WIDTH-1:0]        ReadRegister2,
    input  logic [DATA_WIDTH-1:0]        RegReadData1,
    input  logic [DATA_WIDTH-1:0]        RegReadData2,
    output logic [DATA_WIDTH-1:0]        ReadData1,
    output logic [DATA_WIDTH-1:0]        ReadData2,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] dat;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               empty;
    logic               accept;
    logic               enq;
    logic               pop;
    logic [PTR_W-1:0]   fwd_idx;

    assign empty   = (count_q == '0);
    assign InReady = (count_q != FULL_CNT);
    assign accept  = InValid && InReady && !Reset;
    // Writes to register 0 are swallowed: the regfile hardwires it to zero.
    assign enq     = accept && (InRegister != '0);
    assign pop     = !empty && !Hold && !Reset;

    assign RegWrite      = pop;
    assign WriteRegister = empty ? '0 : mem_q[head_q].rd;
    assign WriteData     = empty ? '0 : mem_q[head_q].dat;
    assign Count         = count_q;
    assign Empty         = empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (enq) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (enq && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !enq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (enq) begin
            mem_q[tail_q] <= '{rd: InRegister, dat: InData};
        end
    end

    // Walk occupied entries oldest to newest so the last match is the newest write.
    always_comb begin
        ReadData1 = RegReadData1;
        ReadData2 = RegReadData2;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((ReadRegister1 != '0) && (mem_q[fwd_idx].rd == ReadRegister1)) begin
                    ReadData1 = mem_q[fwd_idx].dat;
                end
                if ((ReadRegister2 != '0) && (mem_q[fwd_idx].rd == ReadRegister2)) begin
                    ReadData2 = mem_q[fwd_idx].dat;
                end
            end
        end
    end

endmodule
